fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch and issue stage that feeds the control unit. Holds the PC, fetches 32-bit instruction words from instruction memory over a req/ready handshake, and presents opcode/func to the decoder. It then consumes the decoder's `cu_pc_src` and `cu_cont` back to select the next PC or to halt. It sits between instruction memory and `controlu_module`, closing the fetch/decode loop.

## Interface
- `ADDR_W`, 32: PC and memory address width.
- `RESET_PC`, 0: PC value loaded on reset; word aligned.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: fetch request.
- `imem_addr` out ADDR_W: fetch address, equals `pc`.
- `imem_ready` in 1: memory accepts the request and `imem_rdata` is valid this cycle.
- `imem_rdata` in 32: instruction word.
- `instr` out 32: registered instruction being issued.
- `opcode` out 6: `instr[31:26]`, to the decoder.
- `func` out 6: `instr[5:0]`, to the decoder.
- `instr_valid` out 1: `instr` is being issued this cycle.
- `stall` in 1: downstream hold; freezes issue.
- `cu_pc_src` in 2: next-PC select from the decoder, valid while `instr_valid`.
- `cu_cont` in 1: decoder says continue; 0 means the halt instruction (opcode 0, func 0).
- `reg_target` in ADDR_W: register value for register jumps.
- `pc` out ADDR_W: address of the current instruction.
- `halted` out 1: core halted.
- `instr_count` out 32: number of issued (retired) instructions.

## Operation
- The FSM has four states: IDLE, FETCH, ISSUE, HALT.
- **IDLE:** the one cycle after reset release, then go to FETCH.
- **FETCH:**
  - `imem_req`=1 and `imem_addr`=`pc`, both held stable until `imem_ready`.
  - On `imem_ready`, capture `imem_rdata` into `instr` and go to ISSUE.
- **ISSUE:**
  - `instr_valid`=1.
  - If `stall`=1, remain in ISSUE with `instr`, `pc` and `instr_count` unchanged.
  - If `stall`=0 and `cu_cont`=0, go to HALT with `pc` unchanged.
  - If `stall`=0 and `cu_cont`=1, load `pc` with the next PC, increment `instr_count`, and go to FETCH.
- **HALT:** terminal state with `halted`=1 and `imem_req`=0. Only `rst_n` exits it.
- Next-PC encoding, where `seq` = `pc`+4:
  - `00`: `seq`.
  - `01`: `{reg_target[ADDR_W-1:2], 2'b00}`, i.e. register jump with the low bits forced to 0.
  - `10`: `{seq[31:28], instr[25:0], 2'b00}`, absolute jump.
  - `11`: `seq + (sign_extend(instr[15:0]) << 2)`, branch taken.
- Arithmetic is modulo 2^ADDR_W. `pc` = 0xFFFF_FFFC with select `00` wraps to 0.
- `instr_count` wraps from 0xFFFF_FFFF to 0.
- The halt instruction is counted as not issued, so `instr_count` is not incremented on it.

## Timing
- Reset values: `pc`=`RESET_PC`, `instr`=0, `instr_valid`=0, `imem_req`=0, `halted`=0, `instr_count`=0, state=IDLE.
- The first `imem_req` is asserted 1 cycle after reset release.
- With `imem_ready` tied high, throughput is one instruction per 2 cycles (FETCH, ISSUE).
- Each extra wait cycle on `imem_ready` adds one cycle.
- `cu_pc_src` and `cu_cont` are sampled combinationally in ISSUE at the edge where `stall`=0. Their values during stalled cycles are ignored.
- Reset asserted mid-FETCH:
  - `imem_req` drops immediately (asynchronous).
  - A late `imem_ready` after reset is ignored.
  - Fetch restarts at `RESET_PC`.
- `imem_ready` while not in FETCH is ignored.

## Structure
- Shared package holds the PC-select constants `PC_SEL_SEQ`=00, `PC_SEL_REG`=01, `PC_SEL_JUMP`=10, `PC_SEL_BRANCH`=11, plus the FSM state encoding.
- The decoder uses the same PC-select constants.
- One combinational sub-module, `next_pc_module`:
  - Inputs: `pc`, `instr`, `reg_target`, `cu_pc_src`.
  - Output: next PC.
  - It must be unit-testable standalone.
- The FSM, PC, instruction and counter registers live in `fetch_unit`.

## Test plan
- Reset with `RESET_PC`=0x100 and `imem_ready`=1, memory returning an ADD (opcode 0, func 0x20) at every address, decoder model returning `cu_pc_src`=00 and `cu_cont`=1:
  - `imem_addr` sequence 0x100, 0x104, 0x108.
  - `instr_valid` high every second cycle.
  - `instr_count`=3 after 6 cycles.
- `imem_ready` delayed 3 cycles → `imem_req` and `imem_addr` stable for 4 cycles, then `instr` updates.
- Branch: `pc`=0x200, `instr[15:0]`=0xFFFE, select `11` → next `imem_addr`=0x1FC.
- Jumps:
  - `instr[25:0]`=0x40 with select `10` at `pc`=0x3000_0000 → next address 0x3000_0100.
  - `reg_target`=0x1237 with select `01` → 0x1234.
- `stall` held for 5 cycles in ISSUE → `instr_valid` stays 1, `pc` and `instr_count` unchanged, no `imem_req`.
- Halt:
  - Word 0x0000_0000 issued with `cu_cont`=0 → `halted`=1 and `imem_req` stays 0 for 20 cycles.
  - Then pulse `rst_n` low → fetch restarts at `RESET_PC` and `instr_count`=0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch/decode loop: PC-select codes used by both
// the fetch stage and the decoder, plus the fetch FSM state encoding.
package fetch_unit_pkg;

   localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
   localparam logic [1:0] PC_SEL_REG    = 2'b01;
   localparam logic [1:0] PC_SEL_JUMP   = 2'b10;
   localparam logic [1:0] PC_SEL_BRANCH = 2'b11;

   localparam int INSTR_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_FETCH = 2'b01,
      ST_ISSUE = 2'b10,
      ST_HALT  = 2'b11
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC selection: sequential, register jump, absolute jump
// within the current 256 MB region, and PC-relative branch.
module next_pc_module
   import fetch_unit_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0]  pc,
   input  logic [INSTR_W-1:0] instr,
   input  logic [ADDR_W-1:0]  reg_target,
   input  logic [1:0]         cu_pc_src,
   output logic [ADDR_W-1:0]  next_pc
);

   logic [ADDR_W-1:0]        seq;
   logic [ADDR_W-1:0]        jump_target;
   logic [ADDR_W-1:0]        reg_aligned;
   logic signed [ADDR_W-1:0] branch_off;
   logic                     unused_bits;

   assign seq         = pc + ADDR_W'(4);
   assign reg_aligned = {reg_target[ADDR_W-1:2], 2'b00};
   assign jump_target = {seq[ADDR_W-1:28], instr[25:0], 2'b00};
   // Word offset: sign-extend the 16-bit immediate and scale by 4.
   assign branch_off  = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
   assign unused_bits = ^{instr[31:26], reg_target[1:0]};

   always_comb begin
      next_pc = seq;
      case (cu_pc_src)
         PC_SEL_SEQ:    next_pc = seq;
         PC_SEL_REG:    next_pc = reg_aligned;
         PC_SEL_JUMP:   next_pc = jump_target;
         PC_SEL_BRANCH: next_pc = seq + $unsigned(branch_off);
         default:       next_pc = seq;
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch/issue stage: fetches over a req/ready handshake, issues to
// the decoder, and follows the decoder's next-PC select or halt decision.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ready,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr,
   output logic [5:0]         opcode,
   output logic [5:0]         func,
   output logic               instr_valid,
   input  logic               stall,
   input  logic [1:0]         cu_pc_src,
   input  logic               cu_cont,
   input  logic [ADDR_W-1:0]  reg_target,
   output logic [ADDR_W-1:0]  pc,
   output logic               halted,
   output logic [31:0]        instr_count
);

   fetch_state_t      state;
   fetch_state_t      state_next;
   logic              capture;
   logic              advance;
   logic [ADDR_W-1:0] pc_next;

   next_pc_module #(
      .ADDR_W (ADDR_W)
   ) u_next_pc (
      .pc         (pc),
      .instr      (instr),
      .reg_target (reg_target),
      .cu_pc_src  (cu_pc_src),
      .next_pc    (pc_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   // Outputs decode from state only, so imem_req drops with the async reset.
   always_comb begin
      state_next  = state;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      halted      = 1'b0;
      capture     = 1'b0;
      advance     = 1'b0;
      case (state)
         ST_IDLE: state_next = ST_FETCH;
         ST_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               capture    = 1'b1;
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            instr_valid = 1'b1;
            if (!stall) begin
               if (cu_cont) begin
                  advance    = 1'b1;
                  state_next = ST_FETCH;
               end else begin
                  state_next = ST_HALT;
               end
            end
         end
         ST_HALT: halted = 1'b1;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         instr       <= '0;
         instr_count <= '0;
      end else begin
         if (capture) instr <= imem_rdata;
         if (advance) begin
            pc          <= pc_next;
            instr_count <= instr_count + 32'd1;
         end
      end
   end

   assign imem_addr = pc;
   assign opcode    = instr[31:26];
   assign func      = instr[5:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// fetch/issue traffic checked against a transaction-level PC/count model.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [5:0]  func;
   logic        instr_valid;
   logic        stall;
   logic [1:0]  cu_pc_src;
   logic        cu_cont;
   logic [31:0] reg_target;
   logic [31:0] pc;
   logic        halted;
   logic [31:0] instr_count;

   int checks = 0;
   int errors = 0;

   // bench knobs
   logic [31:0] mem [logic [31:0]];
   int          ready_delay = 0;
   int          wcnt = 0;
   int          noise = 0;       // 0: ready low outside fetch, 1: random, 2: always high
   bit          fill_add = 1'b1;
   logic [1:0]  sel = PC_SEL_SEQ;

   // reference model state
   logic [31:0] model_pc;
   logic [31:0] model_cnt;

   always #5 clk = ~clk;

   fetch_unit #(
      .ADDR_W   (32),
      .RESET_PC (RST_PC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .opcode      (opcode),
      .func        (func),
      .instr_valid (instr_valid),
      .stall       (stall),
      .cu_pc_src   (cu_pc_src),
      .cu_cont     (cu_cont),
      .reg_target  (reg_target),
      .pc          (pc),
      .halted      (halted),
      .instr_count (instr_count)
   );

   function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] w,
                                            input logic [31:0] rt, input logic [1:0] s);
      logic [31:0] seq;
      seq = p + 32'd4;
      case (s)
         2'd0:    return seq;
         2'd1:    return rt & 32'hFFFF_FFFC;
         2'd2:    return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
         default: return seq + 32'(signed'(w[15:0])) * 32'd4;
      endcase
   endfunction

   // One clock: memory and decoder respond at the falling edge, then sample
   // shortly after the rising edge.
   task automatic cycle();
      @(negedge clk);
      if (imem_req) begin
         if (!mem.exists(imem_addr))
            mem[imem_addr] = fill_add ? 32'h0000_0020 : ($urandom | 32'h0400_0000);
         imem_rdata = mem[imem_addr];
         if (wcnt >= ready_delay) begin
            imem_ready = 1'b1;
            wcnt = 0;
         end else begin
            imem_ready = 1'b0;
            wcnt++;
         end
      end else begin
         imem_ready = (noise == 2) ? 1'b1 : (noise == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         imem_rdata = $urandom;
         wcnt = 0;
      end
      cu_cont   = !(opcode == 6'd0 && func == 6'd0);
      if (stall) cu_cont = 1'($urandom_range(0, 1));
      cu_pc_src = sel;
      @(posedge clk);
      #1;
   endtask

   // Fetch one instruction at model_pc, optionally stall, then issue with s/rt.
   task automatic issue_one(input logic [1:0] s, input logic [31:0] rt, input int nstall);
      int          n;
      logic [31:0] w;
      logic [31:0] exp_pc;
      stall = 1'b0;
      n = 0;
      while (!instr_valid && n < 12) begin
         cycle();
         if (imem_req) begin
            checks++;
            if (imem_addr !== model_pc) begin
               errors++;
               $display("FAIL fetch_addr: got %h want %h", imem_addr, model_pc);
            end
         end
         n++;
      end
      checks++;
      if (!instr_valid) begin
         errors++;
         $display("FAIL issue_timeout: instr_valid never rose at pc %h", model_pc);
         return;
      end
      w = mem[model_pc];
      checks++;
      if (instr !== w) begin
         errors++;
         $display("FAIL issued_instr: got %h want %h", instr, w);
      end
      stall = 1'b1;
      for (int i = 0; i < nstall; i++) begin
         sel        = 2'($urandom_range(0, 3));
         reg_target = $urandom;
         cycle();
         checks++;
         if (instr_valid !== 1'b1 || pc !== model_pc || instr_count !== model_cnt ||
             imem_req !== 1'b0 || instr !== w) begin
            errors++;
            $display("FAIL stall_hold: valid %b pc %h cnt %0d req %b, want valid 1 pc %h cnt %0d req 0",
                     instr_valid, pc, instr_count, imem_req, model_pc, model_cnt);
         end
      end
      stall      = 1'b0;
      sel        = s;
      reg_target = rt;
      exp_pc     = ref_next(model_pc, w, rt, s);
      cycle();
      model_pc  = exp_pc;
      model_cnt = model_cnt + 32'd1;
      checks++;
      if (pc !== model_pc || instr_count !== model_cnt || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL next_pc: pc %h cnt %0d valid %b, want pc %h cnt %0d valid 0 (sel %0d)",
                  pc, instr_count, instr_valid, model_pc, model_cnt, s);
      end
   endtask

   task automatic test_reset();
      checks++;
      if (pc !== RST_PC || instr !== 32'd0 || instr_valid !== 1'b0 || imem_req !== 1'b0 ||
          halted !== 1'b0 || instr_count !== 32'd0) begin
         errors++;
         $display("FAIL reset_values: pc %h instr %h valid %b req %b halt %b cnt %0d",
                  pc, instr, instr_valid, imem_req, halted, instr_count);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_req: got %b want 0", imem_req);
      end
      model_pc  = RST_PC;
      model_cnt = 32'd0;
   endtask

   task automatic test_sequential();
      logic [31:0] exp_addr;
      fill_add = 1'b1; ready_delay = 0; noise = 0; sel = PC_SEL_SEQ; stall = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         cycle();
         exp_addr = RST_PC + 32'(4 * ((k - 1) / 2));
         checks++;
         if (imem_req !== 1'(k % 2) || instr_valid !== 1'((k + 1) % 2) ||
             (imem_req && imem_addr !== exp_addr)) begin
            errors++;
            $display("FAIL seq_cycle%0d: req %b valid %b addr %h, want req %0d valid %0d addr %h",
                     k, imem_req, instr_valid, imem_addr, k % 2, (k + 1) % 2, exp_addr);
         end
      end
      checks++;
      if (instr_count !== 32'd3) begin
         errors++;
         $display("FAIL seq_count: got %0d want 3", instr_count);
      end
      model_pc  = RST_PC + 32'd12;
      model_cnt = 32'd3;
   endtask

   task automatic test_wait();
      mem[model_pc] = 32'h2000_1234;
      ready_delay = 3;
      for (int i = 1; i <= 3; i++) begin
         cycle();
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== model_pc || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_hold%0d: req %b addr %h valid %b, want 1 %h 0",
                     i, imem_req, imem_addr, instr_valid, model_pc);
         end
      end
      cycle();
      checks++;
      if (instr_valid !== 1'b1 || instr !== 32'h2000_1234) begin
         errors++;
         $display("FAIL wait_capture: valid %b instr %h, want 1 20001234", instr_valid, instr);
      end
      ready_delay = 0;
      sel = PC_SEL_SEQ;
      cycle();
      model_pc  = model_pc + 32'd4;
      model_cnt = model_cnt + 32'd1;
      checks++;
      if (pc !== model_pc || instr_count !== model_cnt) begin
         errors++;
         $display("FAIL wait_advance: pc %h cnt %0d, want %h %0d", pc, instr_count, model_pc, model_cnt);
      end
   endtask

   task automatic test_jumps();
      issue_one(PC_SEL_REG, 32'h0000_0200, 0);
      mem[32'h0000_0200] = 32'h1000_FFFE;
      issue_one(PC_SEL_BRANCH, $urandom, 0);
      checks++;
      if (pc !== 32'h0000_01FC) begin
         errors++;
         $display("FAIL branch_back: got %h want 000001fc", pc);
      end
      issue_one(PC_SEL_REG, 32'h3000_0000, 0);
      mem[32'h3000_0000] = 32'h0800_0040;
      issue_one(PC_SEL_JUMP, $urandom, 0);
      checks++;
      if (pc !== 32'h3000_0100) begin
         errors++;
         $display("FAIL abs_jump: got %h want 30000100", pc);
      end
      issue_one(PC_SEL_REG, 32'h0000_1237, 0);
      checks++;
      if (pc !== 32'h0000_1234) begin
         errors++;
         $display("FAIL reg_jump: got %h want 00001234", pc);
      end
      issue_one(PC_SEL_REG, 32'hFFFF_FFFF, 0);
      issue_one(PC_SEL_SEQ, $urandom, 0);
      checks++;
      if (pc !== 32'd0) begin
         errors++;
         $display("FAIL pc_wrap: got %h want 00000000", pc);
      end
   endtask

   task automatic test_stall();
      issue_one(PC_SEL_SEQ, 32'd0, 5);
   endtask

   task automatic test_random();
      fill_add = 1'b0;
      noise = 1;
      for (int i = 0; i < 40; i++) begin
         ready_delay = $urandom_range(0, 3);
         issue_one(2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 2));
      end
      fill_add = 1'b1;
      ready_delay = 0;
   endtask

   task automatic test_reset_mid_fetch();
      ready_delay = 5;
      noise = 2;
      cycle();
      cycle();
      checks++;
      if (imem_req !== 1'b1) begin
         errors++;
         $display("FAIL mid_fetch_setup: req %b want 1", imem_req);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b0 || pc !== RST_PC) begin
         errors++;
         $display("FAIL async_drop: req %b pc %h, want 0 %h", imem_req, pc, RST_PC);
      end
      cycle();
      cycle();
      rst_n = 1'b1;
      ready_delay = 0;
      cycle();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== RST_PC || instr_valid !== 1'b0 || instr !== 32'd0) begin
         errors++;
         $display("FAIL restart_fetch: req %b addr %h valid %b instr %h, want 1 %h 0 0",
                  imem_req, imem_addr, instr_valid, instr, RST_PC);
      end
      noise = 1;
      model_pc  = RST_PC;
      model_cnt = 32'd0;
      issue_one(PC_SEL_SEQ, 32'd0, 0);
   endtask

   task automatic test_halt();
      int n;
      mem[model_pc] = 32'h0000_0000;
      stall = 1'b0;
      n = 0;
      while (!instr_valid && n < 12) begin
         cycle();
         n++;
      end
      checks++;
      if (instr_valid !== 1'b1 || instr !== 32'd0) begin
         errors++;
         $display("FAIL halt_issue: valid %b instr %h, want 1 00000000", instr_valid, instr);
      end
      sel = 2'($urandom_range(0, 3));
      cycle();
      checks++;
      if (halted !== 1'b1 || pc !== model_pc || instr_count !== model_cnt || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL halt_enter: halt %b pc %h cnt %0d valid %b, want 1 %h %0d 0",
                  halted, pc, instr_count, instr_valid, model_pc, model_cnt);
      end
      for (int i = 0; i < 20; i++) begin
         cycle();
         checks++;
         if (imem_req !== 1'b0 || halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_hold%0d: req %b halt %b, want 0 1", i, imem_req, halted);
         end
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (halted !== 1'b0 || instr_count !== 32'd0 || pc !== RST_PC) begin
         errors++;
         $display("FAIL halt_reset: halt %b cnt %0d pc %h, want 0 0 %h", halted, instr_count, pc, RST_PC);
      end
      cycle();
      rst_n = 1'b1;
      cycle();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
         errors++;
         $display("FAIL halt_restart: req %b addr %h, want 1 %h", imem_req, imem_addr, RST_PC);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      imem_ready = 1'b0;
      imem_rdata = 32'd0;
      stall      = 1'b0;
      cu_pc_src  = PC_SEL_SEQ;
      cu_cont    = 1'b1;
      reg_target = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_sequential();
      test_wait();
      test_jumps();
      test_stall();
      test_random();
      test_reset_mid_fetch();
      test_halt();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
